// File: rtl/morse_encoder.sv
// morse_encoder: serial ITU Morse keyer for ASCII letters, digits and space
module morse_encoder #(
   parameter int UNIT_CYCLES = 65
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic [7:0] letter,
   input  logic       start,
   output logic       ready,
   output logic       signal,
   output logic       done,
   output logic       err
);
   localparam int CW = $clog2(4 * UNIT_CYCLES);
   localparam logic [CW-1:0] U1 = CW'(UNIT_CYCLES - 1);
   localparam logic [CW-1:0] U3 = CW'(3 * UNIT_CYCLES - 1);
   localparam logic [CW-1:0] U4 = CW'(4 * UNIT_CYCLES - 1);
   typedef enum logic [2:0] {IDLE, MARK, GAP, LGAP, WGAP, FAIL} state_t;
   state_t state;
   logic [CW-1:0] cnt;
   logic [4:0] pat;
   logic [2:0] rem;
   logic [7:0] ch;
   logic [7:0] code;
   logic is_space;
   // {length, pattern}; pattern left-aligned so the first element is bit 4, 1 = dah
   function automatic logic [7:0] lookup(input logic [7:0] c);
      case (c)
         "A": lookup = {3'd2, 5'b01000};
         "B": lookup = {3'd4, 5'b10000};
         "C": lookup = {3'd4, 5'b10100};
         "D": lookup = {3'd3, 5'b10000};
         "E": lookup = {3'd1, 5'b00000};
         "F": lookup = {3'd4, 5'b00100};
         "G": lookup = {3'd3, 5'b11000};
         "H": lookup = {3'd4, 5'b00000};
         "I": lookup = {3'd2, 5'b00000};
         "J": lookup = {3'd4, 5'b01110};
         "K": lookup = {3'd3, 5'b10100};
         "L": lookup = {3'd4, 5'b01000};
         "M": lookup = {3'd2, 5'b11000};
         "N": lookup = {3'd2, 5'b10000};
         "O": lookup = {3'd3, 5'b11100};
         "P": lookup = {3'd4, 5'b01100};
         "Q": lookup = {3'd4, 5'b11010};
         "R": lookup = {3'd3, 5'b01000};
         "S": lookup = {3'd3, 5'b00000};
         "T": lookup = {3'd1, 5'b10000};
         "U": lookup = {3'd3, 5'b00100};
         "V": lookup = {3'd4, 5'b00010};
         "W": lookup = {3'd3, 5'b01100};
         "X": lookup = {3'd4, 5'b10010};
         "Y": lookup = {3'd4, 5'b10110};
         "Z": lookup = {3'd4, 5'b11000};
         "0": lookup = {3'd5, 5'b11111};
         "1": lookup = {3'd5, 5'b01111};
         "2": lookup = {3'd5, 5'b00111};
         "3": lookup = {3'd5, 5'b00011};
         "4": lookup = {3'd5, 5'b00001};
         "5": lookup = {3'd5, 5'b00000};
         "6": lookup = {3'd5, 5'b10000};
         "7": lookup = {3'd5, 5'b11000};
         "8": lookup = {3'd5, 5'b11100};
         "9": lookup = {3'd5, 5'b11110};
         default: lookup = 8'h00;
      endcase
   endfunction
   // fold lowercase onto uppercase and decode; zero length marks unsupported
   always_comb begin
      ch = (letter >= 8'h61 && letter <= 8'h7A) ? letter - 8'h20 : letter;
      code = lookup(ch);
      is_space = letter == 8'h20;
   end
   // keying FSM: single down-counter holds the remaining cycles of the current phase
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state <= IDLE;
         cnt <= '0;
         pat <= '0;
         rem <= '0;
         ready <= 1'b1;
         signal <= 1'b0;
         done <= 1'b0;
         err <= 1'b0;
      end else begin
         done <= 1'b0;
         err <= 1'b0;
         case (state)
            IDLE: if (start) begin
               ready <= 1'b0;
               if (is_space) begin
                  state <= WGAP;
                  cnt <= U4;
               end else if (code[7:5] != 3'd0) begin
                  state <= MARK;
                  signal <= 1'b1;
                  cnt <= code[4] ? U3 : U1;
                  pat <= {code[3:0], 1'b0};
                  rem <= code[7:5] - 3'd1;
               end else begin
                  state <= FAIL;
                  done <= 1'b1;
                  err <= 1'b1;
               end
            end
            MARK: if (cnt == '0) begin
               signal <= 1'b0;
               state <= (rem != 3'd0) ? GAP : LGAP;
               cnt <= (rem != 3'd0) ? U1 : U3;
            end else cnt <= cnt - CW'(1);
            GAP: if (cnt == '0) begin
               state <= MARK;
               signal <= 1'b1;
               cnt <= pat[4] ? U3 : U1;
               pat <= pat << 1;
               rem <= rem - 3'd1;
            end else cnt <= cnt - CW'(1);
            LGAP, WGAP: if (cnt == '0) begin
               state <= IDLE;
               ready <= 1'b1;
            end else begin
               cnt <= cnt - CW'(1);
               done <= cnt == CW'(1);
            end
            FAIL: begin
               state <= IDLE;
               ready <= 1'b1;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_morse_encoder.sv
// tb_morse_encoder: directed scoreboard bench for morse_encoder at UNIT_CYCLES=4
module tb_morse_encoder;
   localparam int U = 4;
   logic clk = 1'b0;
   logic reset_n = 1'b0;
   logic [7:0] letter = 8'h00;
   logic start = 1'b0;
   logic ready, signal, done, err;
   logic [3:0] q[$];
   int n_assert = 0;
   int n_fail = 0;

   morse_encoder #(.UNIT_CYCLES(U)) dut (
      .clk(clk), .reset_n(reset_n), .letter(letter), .start(start),
      .ready(ready), .signal(signal), .done(done), .err(err)
   );

   always #5 clk = ~clk;

   initial begin
      #1ms;
      $display("FAIL watchdog: observed timeout expected finish");
      $fatal(1, "timeout");
   end

   function automatic string morse(input byte c);
      byte u;
      u = (c >= "a" && c <= "z") ? c - 8'sd32 : c;
      case (u)
         "A": return ".-";    "B": return "-...";  "C": return "-.-.";  "D": return "-..";
         "E": return ".";     "F": return "..-.";  "G": return "--.";   "H": return "....";
         "I": return "..";    "J": return ".---";  "K": return "-.-";   "L": return ".-..";
         "M": return "--";    "N": return "-.";    "O": return "---";   "P": return ".--.";
         "Q": return "--.-";  "R": return ".-.";   "S": return "...";   "T": return "-";
         "U": return "..-";   "V": return "...-";  "W": return ".--";   "X": return "-..-";
         "Y": return "-.--";  "Z": return "--..";
         "0": return "-----"; "1": return ".----"; "2": return "..---"; "3": return "...--";
         "4": return "....-"; "5": return "....."; "6": return "-...."; "7": return "--...";
         "8": return "---.."; "9": return "----.";
         " ": return "";
         default: return "?";
      endcase
   endfunction

   // expected {signal, done, err, ready} per cycle following acceptance
   task automatic push_expected(input byte c);
      string m;
      m = morse(c);
      if (m == "?") q.push_back(4'b0110);
      else if (m.len() == 0) begin
         for (int i = 0; i < 4 * U - 1; i++) q.push_back(4'b0000);
         q.push_back(4'b0100);
      end else begin
         for (int e = 0; e < m.len(); e++) begin
            for (int i = 0; i < ((m[e] == "-") ? 3 * U : U); i++) q.push_back(4'b1000);
            if (e < m.len() - 1) for (int i = 0; i < U; i++) q.push_back(4'b0000);
         end
         for (int i = 0; i < 3 * U - 1; i++) q.push_back(4'b0000);
         q.push_back(4'b0100);
      end
   endtask

   task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %b expected %b (signal,done,err,ready)", tag, obs, exp);
      end
   endtask

   // called at a negedge with the DUT idle; returns at the negedge of the idle cycle after done
   task automatic run_char(input byte c, input bit hold);
      string tag;
      int k;
      tag = $sformatf("char_%02h", c);
      letter = c;
      start = 1'b1;
      push_expected(c);
      k = 0;
      while (q.size() > 0) begin
         @(negedge clk);
         if (!hold) start = 1'b0;
         letter = 8'h23;
         check($sformatf("%s_cyc%0d", tag, k), {signal, done, err, ready}, q.pop_front());
         k++;
      end
      @(negedge clk);
      check({tag, "_ready"}, {signal, done, err, ready}, 4'b0001);
   endtask

   initial begin
      @(negedge clk);
      check("reset", {signal, done, err, ready}, 4'b0001);
      @(negedge clk);
      reset_n = 1'b1;
      run_char("E", 1'b0);
      run_char("A", 1'b0);
      run_char("a", 1'b0);
      run_char("0", 1'b0);
      run_char("#", 1'b0);
      run_char("@", 1'b0);
      run_char("[", 1'b0);
      run_char("/", 1'b0);
      run_char(":", 1'b0);
      run_char("z", 1'b0);
      run_char("9", 1'b0);
      run_char("Q", 1'b0);
      run_char("M", 1'b1);
      run_char(" ", 1'b1);
      run_char("K", 1'b1);
      start = 1'b0;
      repeat (3) begin
         @(negedge clk);
         check("idle_after_hold", {signal, done, err, ready}, 4'b0001);
      end
      letter = "T";
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int i = 0; i < 5; i++) begin
         check("t_dah_before_reset", {signal, done, err, ready}, 4'b1000);
         @(negedge clk);
      end
      #2 reset_n = 1'b0;
      #1 check("async_reset", {signal, done, err, ready}, 4'b0001);
      @(negedge clk);
      reset_n = 1'b1;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         check("post_reset_quiet", {signal, done, err, ready}, 4'b0001);
      end
      run_char("T", 1'b0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule
